// File: rtl/uart_pkg.sv
// Shared definitions for the uart8 receiver/transmitter slice.
package uart_pkg;

    typedef enum logic [1:0] {IDLE, START, DATA, STOP} uartState;

    // Counter width for a divide-by-div counter; never narrower than 1 bit.
    function automatic int divWidth(input int div);
        return (div > 1) ? $clog2(div) : 1;
    endfunction

endpackage

// File: rtl/baud_tick_gen.sv
// Free-running divide-by-DIV counter; tick is high for the last clock of each period.
module baud_tick_gen import uart_pkg::*; #(
    parameter int DIV = 78
) (
    input  logic clk,
    input  logic reset,
    input  logic clear,
    output logic tick
);

    localparam int W = divWidth(DIV);
    localparam logic [W-1:0] LAST = W'(DIV - 1);

    logic [W-1:0] count;

    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            count <= '0;
        else if (clear || count == LAST)
            count <= '0;
        else
            count <= count + 1'b1;
    end

    // Combinational so a state change lands exactly DIV clocks after clear drops.
    assign tick = !clear && (count == LAST);

endmodule

// File: rtl/uart_rx.sv
// 8N1 receiver: oversampled, mid-bit sampling, returns to IDLE at mid-stop-bit.
module uart_rx import uart_pkg::*; #(
    parameter int CLOCK_RATE    = 12000000,
    parameter int BAUD_RATE     = 9600,
    parameter int RX_OVERSAMPLE = 16
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       rxEn,
    input  logic       rx,
    output logic       rxBusy,
    output logic       rxDone,
    output logic       rxErr,
    output logic [7:0] out
);

    localparam int RX_DIV = CLOCK_RATE / (BAUD_RATE * RX_OVERSAMPLE);
    localparam int CW = divWidth(RX_OVERSAMPLE);
    localparam logic [CW-1:0] HALF_LAST = CW'(RX_OVERSAMPLE / 2 - 1);
    localparam logic [CW-1:0] BIT_LAST  = CW'(RX_OVERSAMPLE - 1);

    uartState state, nextState;
    logic          rxMeta, rxSync, tick, halfPoint, bitPoint;
    logic [CW-1:0] sampleCnt;
    logic [2:0]    bitCnt;
    logic [7:0]    shiftReg;

    baud_tick_gen #(.DIV(RX_DIV)) tickGen (
        .clk(clk), .reset(reset), .clear(state == IDLE), .tick(tick)
    );

    assign halfPoint = tick && (sampleCnt == HALF_LAST);
    assign bitPoint  = tick && (sampleCnt == BIT_LAST);

    // Synchronizer resets to the idle line level so reset never looks like a start bit.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rxMeta <= 1'b1;
            rxSync <= 1'b1;
        end else begin
            rxMeta <= rx;
            rxSync <= rxMeta;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) state <= IDLE;
        else       state <= nextState;
    end

    always_comb begin
        nextState = state;
        case (state)
            IDLE:    if (!rxSync) nextState = START;
            START:   if (halfPoint) nextState = rxSync ? IDLE : DATA;
            DATA:    if (bitPoint && bitCnt == 3'd7) nextState = STOP;
            STOP:    if (bitPoint) nextState = IDLE;
            default: nextState = IDLE;
        endcase
        if (!rxEn) nextState = IDLE;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sampleCnt <= '0;
            bitCnt    <= '0;
            shiftReg  <= '0;
            out       <= '0;
            rxDone    <= 1'b0;
            rxErr     <= 1'b0;
        end else begin
            rxDone <= 1'b0;
            rxErr  <= 1'b0;
            if (state == IDLE || (state == START && halfPoint) || bitPoint)
                sampleCnt <= '0;
            else if (tick)
                sampleCnt <= sampleCnt + 1'b1;
            if (state == START)
                bitCnt <= '0;
            if (state == DATA && bitPoint) begin
                shiftReg <= {rxSync, shiftReg[7:1]};
                bitCnt   <= bitCnt + 1'b1;
            end
            if (state == STOP && bitPoint && rxEn) begin
                if (rxSync) begin
                    out    <= shiftReg;
                    rxDone <= 1'b1;
                end else begin
                    rxErr <= 1'b1;
                end
            end
        end
    end

    // Busy only once the start bit is confirmed, so false starts never show.
    always_comb begin
        rxBusy = (state == DATA) || (state == STOP);
    end

endmodule

// File: rtl/uart_tx.sv
// 8N1 transmitter: start bit, 8 data bits LSB-first, stop bit, one bit per baud tick.
module uart_tx import uart_pkg::*; #(
    parameter int CLOCK_RATE = 12000000,
    parameter int BAUD_RATE  = 9600
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       txEn,
    input  logic       txStart,
    input  logic [7:0] in,
    output logic       tx,
    output logic       txBusy,
    output logic       txDone
);

    localparam int TX_DIV = CLOCK_RATE / BAUD_RATE;

    uartState   state, nextState;
    logic       tick;
    logic [2:0] bitCnt;
    logic [7:0] shiftReg;

    baud_tick_gen #(.DIV(TX_DIV)) tickGen (
        .clk(clk), .reset(reset), .clear(state == IDLE), .tick(tick)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) state <= IDLE;
        else       state <= nextState;
    end

    always_comb begin
        nextState = state;
        case (state)
            IDLE:    if (txStart) nextState = START;
            START:   if (tick) nextState = DATA;
            DATA:    if (tick && bitCnt == 3'd7) nextState = STOP;
            STOP:    if (tick) nextState = IDLE;
            default: nextState = IDLE;
        endcase
        if (!txEn) nextState = IDLE;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            bitCnt   <= '0;
            shiftReg <= '0;
            txDone   <= 1'b0;
        end else begin
            txDone <= 1'b0;
            if (state == IDLE && txEn && txStart)
                shiftReg <= in;
            if (state == START)
                bitCnt <= '0;
            if (state == DATA && tick) begin
                shiftReg <= {1'b0, shiftReg[7:1]};
                bitCnt   <= bitCnt + 1'b1;
            end
            if (state == STOP && tick && txEn)
                txDone <= 1'b1;
        end
    end

    always_comb begin
        txBusy = (state != IDLE);
        case (state)
            START:   tx = 1'b0;
            DATA:    tx = shiftReg[0];
            default: tx = 1'b1;
        endcase
    end

endmodule

// File: rtl/uart8.sv
// 8N1 UART top: independent receiver and transmitter sharing one clock.
module uart8 import uart_pkg::*; #(
    parameter int CLOCK_RATE    = 12000000,
    parameter int BAUD_RATE     = 9600,
    parameter int RX_OVERSAMPLE = 16
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       rxEn,
    input  logic       rx,
    output logic       rxBusy,
    output logic       rxDone,
    output logic       rxErr,
    output logic [7:0] out,
    input  logic       txEn,
    input  logic       txStart,
    input  logic [7:0] in,
    output logic       tx,
    output logic       txBusy,
    output logic       txDone
);

    uart_rx #(
        .CLOCK_RATE(CLOCK_RATE), .BAUD_RATE(BAUD_RATE), .RX_OVERSAMPLE(RX_OVERSAMPLE)
    ) rxUnit (
        .clk(clk), .reset(reset), .rxEn(rxEn), .rx(rx),
        .rxBusy(rxBusy), .rxDone(rxDone), .rxErr(rxErr), .out(out)
    );

    uart_tx #(
        .CLOCK_RATE(CLOCK_RATE), .BAUD_RATE(BAUD_RATE)
    ) txUnit (
        .clk(clk), .reset(reset), .txEn(txEn), .txStart(txStart), .in(in),
        .tx(tx), .txBusy(txBusy), .txDone(txDone)
    );

endmodule

// File: tb/tb_uart8.sv
// Directed bench for uart8 at default rates: 1250 clks per bit, RX tick every 78 clks.
module tb_uart8;

    logic       clk = 1'b0, reset = 1'b1, rxEn = 1'b0, rx = 1'b1;
    logic       txEn = 1'b0, txStart = 1'b0;
    logic [7:0] in = 8'h00;
    logic       rxBusy, rxDone, rxErr, tx, txBusy, txDone;
    logic [7:0] out;

    int tests = 0, fails = 0;
    int rxDoneCnt = 0, rxErrCnt = 0, rxBusyCnt = 0;

    uart8 dut (
        .clk(clk), .reset(reset), .rxEn(rxEn), .rx(rx),
        .rxBusy(rxBusy), .rxDone(rxDone), .rxErr(rxErr), .out(out),
        .txEn(txEn), .txStart(txStart), .in(in),
        .tx(tx), .txBusy(txBusy), .txDone(txDone)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (rxDone) rxDoneCnt++;
        if (rxErr)  rxErrCnt++;
        if (rxBusy) rxBusyCnt++;
    end

    task automatic idle(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic sendBit(input logic v, input int n);
        rx = v;
        repeat (n) @(negedge clk);
    endtask

    task automatic sendFrame(input logic [7:0] b, input int bitClks, input logic stopVal, input int stopClks);
        sendBit(1'b0, bitClks);
        for (int i = 0; i < 8; i++) sendBit(b[i], bitClks);
        sendBit(stopVal, stopClks);
    endtask

    task automatic test_reset;
        idle(4);
        tests++; if (rxBusy !== 1'b0) begin fails++; $display("FAIL reset_rxBusy: got %b want 0", rxBusy); end
        tests++; if (rxDone !== 1'b0) begin fails++; $display("FAIL reset_rxDone: got %b want 0", rxDone); end
        tests++; if (rxErr !== 1'b0) begin fails++; $display("FAIL reset_rxErr: got %b want 0", rxErr); end
        tests++; if (out !== 8'h00) begin fails++; $display("FAIL reset_out: got %h want 00", out); end
        tests++; if (tx !== 1'b1) begin fails++; $display("FAIL reset_tx: got %b want 1", tx); end
        tests++; if (txBusy !== 1'b0) begin fails++; $display("FAIL reset_txBusy: got %b want 0", txBusy); end
        tests++; if (txDone !== 1'b0) begin fails++; $display("FAIL reset_txDone: got %b want 0", txDone); end
        reset = 1'b0;
        rxEn = 1'b1;
        txEn = 1'b1;
    endtask

    task automatic test_idle;
        int b0, b1, b2;
        b0 = rxBusyCnt; b1 = rxDoneCnt; b2 = rxErrCnt;
        idle(24000);
        tests++; if (rxBusyCnt - b0 != 0) begin fails++; $display("FAIL idle_rxBusy: got %0d busy clks want 0", rxBusyCnt - b0); end
        tests++; if (rxDoneCnt - b1 != 0) begin fails++; $display("FAIL idle_rxDone: got %0d pulses want 0", rxDoneCnt - b1); end
        tests++; if (rxErrCnt - b2 != 0) begin fails++; $display("FAIL idle_rxErr: got %0d pulses want 0", rxErrCnt - b2); end
        tests++; if (out !== 8'h00) begin fails++; $display("FAIL idle_out: got %h want 00", out); end
        tests++; if (tx !== 1'b1) begin fails++; $display("FAIL idle_tx: got %b want 1", tx); end
        tests++; if (txBusy !== 1'b0) begin fails++; $display("FAIL idle_txBusy: got %b want 0", txBusy); end
    endtask

    task automatic test_glitch;
        int b0, b1, b2;
        b0 = rxBusyCnt; b1 = rxDoneCnt; b2 = rxErrCnt;
        // 16 us low, then high until just past the false-start check (~52 us after the fall).
        sendBit(1'b0, 192);
        sendBit(1'b1, 440);
        tests++; if (rxBusyCnt - b0 != 0) begin fails++; $display("FAIL glitch_rxBusy: got %0d busy clks want 0", rxBusyCnt - b0); end
        tests++; if (rxDoneCnt - b1 != 0) begin fails++; $display("FAIL glitch_rxDone: got %0d want 0", rxDoneCnt - b1); end
        tests++; if (rxErrCnt - b2 != 0) begin fails++; $display("FAIL glitch_rxErr: got %0d want 0", rxErrCnt - b2); end
        sendFrame(8'h3C, 1250, 1'b1, 1250);
        idle(200);
        tests++; if (rxDoneCnt - b1 != 1) begin fails++; $display("FAIL glitch_frame_done: got %0d want 1", rxDoneCnt - b1); end
        tests++; if (rxErrCnt - b2 != 0) begin fails++; $display("FAIL glitch_frame_err: got %0d want 0", rxErrCnt - b2); end
        tests++; if (out !== 8'h3C) begin fails++; $display("FAIL glitch_frame_out: got %h want 3C", out); end
    endtask

    task automatic test_slow_frame;
        int b1, b2, n;
        b1 = rxDoneCnt; b2 = rxErrCnt;
        sendFrame(8'h56, 1290, 1'b1, 852);
        rx = 1'b0;
        n = 0;
        while (!rxBusy && n < 1000) begin
            @(negedge clk);
            n++;
        end
        tests++; if (rxDoneCnt - b1 != 1) begin fails++; $display("FAIL slow_done: got %0d want 1", rxDoneCnt - b1); end
        tests++; if (rxErrCnt - b2 != 0) begin fails++; $display("FAIL slow_err: got %0d want 0", rxErrCnt - b2); end
        tests++; if (out !== 8'h56) begin fails++; $display("FAIL slow_out: got %h want 56", out); end
        tests++; if (n < 600 || n > 660) begin fails++; $display("FAIL slow_next_start: got %0d clks want 600..660", n); end
    endtask

    task automatic test_abort;
        int b0, b1, b2;
        rxEn = 1'b0;
        @(negedge clk);
        tests++; if (rxBusy !== 1'b0) begin fails++; $display("FAIL abort_rxBusy: got %b want 0", rxBusy); end
        b0 = rxBusyCnt; b1 = rxDoneCnt; b2 = rxErrCnt;
        idle(1500);
        rx = 1'b1;
        idle(50);
        tests++; if (rxBusyCnt - b0 != 0) begin fails++; $display("FAIL abort_busy_held: got %0d want 0", rxBusyCnt - b0); end
        tests++; if (rxDoneCnt - b1 != 0) begin fails++; $display("FAIL abort_done: got %0d want 0", rxDoneCnt - b1); end
        tests++; if (rxErrCnt - b2 != 0) begin fails++; $display("FAIL abort_err: got %0d want 0", rxErrCnt - b2); end
        rxEn = 1'b1;
        idle(20);
    endtask

    task automatic test_framing_err;
        int b1, b2;
        b1 = rxDoneCnt; b2 = rxErrCnt;
        sendFrame(8'hA5, 1250, 1'b0, 1250);
        rx = 1'b1;
        idle(100);
        tests++; if (rxErrCnt - b2 != 1) begin fails++; $display("FAIL ferr_err: got %0d want 1", rxErrCnt - b2); end
        tests++; if (rxDoneCnt - b1 != 0) begin fails++; $display("FAIL ferr_done: got %0d want 0", rxDoneCnt - b1); end
        tests++; if (out !== 8'h56) begin fails++; $display("FAIL ferr_out: got %h want 56", out); end
        // The low stop bit looks like a new start; flush the receiver.
        rxEn = 1'b0;
        idle(2);
        rxEn = 1'b1;
        idle(20);
    endtask

    task automatic test_tx;
        logic [9:0] pat;
        int busyClks, doneCnt, doneAt;
        pat = {1'b1, 8'hA5, 1'b0};
        busyClks = 0; doneCnt = 0; doneAt = -1;
        in = 8'hA5;
        txStart = 1'b1;
        @(negedge clk);
        txStart = 1'b0;
        for (int i = 0; i < 13000; i++) begin
            if (i > 0) @(negedge clk);
            if (i == 3000) begin txStart = 1'b1; in = 8'h00; end
            if (i == 3001) txStart = 1'b0;
            if (txBusy) busyClks++;
            if (txDone) begin doneCnt++; doneAt = i; end
            if (i % 1250 == 625 && i < 12500) begin
                tests++;
                if (tx !== pat[i / 1250]) begin
                    fails++;
                    $display("FAIL tx_bit%0d: got %b want %b", i / 1250, tx, pat[i / 1250]);
                end
            end
        end
        tests++; if (busyClks != 12500) begin fails++; $display("FAIL tx_busy_len: got %0d want 12500", busyClks); end
        tests++; if (doneCnt != 1) begin fails++; $display("FAIL tx_done_cnt: got %0d want 1", doneCnt); end
        tests++; if (doneAt != 12500) begin fails++; $display("FAIL tx_done_at: got %0d want 12500", doneAt); end
        tests++; if (tx !== 1'b1) begin fails++; $display("FAIL tx_idle_after: got %b want 1", tx); end
    endtask

    task automatic test_reset_midframe;
        in = 8'h33;
        txStart = 1'b1;
        rx = 1'b0;
        @(negedge clk);
        txStart = 1'b0;
        idle(700);
        tests++; if (rxBusy !== 1'b1) begin fails++; $display("FAIL mid_rxBusy_pre: got %b want 1", rxBusy); end
        tests++; if (txBusy !== 1'b1) begin fails++; $display("FAIL mid_txBusy_pre: got %b want 1", txBusy); end
        #2 reset = 1'b1;
        #1;
        tests++; if (rxBusy !== 1'b0) begin fails++; $display("FAIL mid_rxBusy: got %b want 0", rxBusy); end
        tests++; if (out !== 8'h00) begin fails++; $display("FAIL mid_out: got %h want 00", out); end
        tests++; if (tx !== 1'b1) begin fails++; $display("FAIL mid_tx: got %b want 1", tx); end
        tests++; if (txBusy !== 1'b0) begin fails++; $display("FAIL mid_txBusy: got %b want 0", txBusy); end
        tests++; if (rxDone !== 1'b0 || rxErr !== 1'b0) begin fails++; $display("FAIL mid_rx_pulses: got %b%b want 00", rxDone, rxErr); end
        tests++; if (txDone !== 1'b0) begin fails++; $display("FAIL mid_txDone: got %b want 0", txDone); end
        rx = 1'b1;
        idle(2);
        reset = 1'b0;
        idle(10);
    endtask

    initial begin
        test_reset;
        test_idle;
        test_glitch;
        test_slow_frame;
        test_abort;
        test_framing_err;
        test_tx;
        test_reset_midframe;
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/uart8.md
Name: uart8

Overview:
- 8N1 UART with an independent receiver and transmitter, single clock domain.
- Receiver oversamples `rx` at 16x the baud rate and checks each bit at mid-bit.
- Transmitter shifts out a byte LSB-first at the baud rate.
- Sits between board pins and a byte-wide user interface; the receiver alone is usable, with the tx ports tied off.

Parameters:
- CLOCK_RATE, 12000000, system clock frequency in Hz.
- BAUD_RATE, 9600, line rate in bit/s.
- RX_OVERSAMPLE, 16, receiver samples per bit; must be even.

Ports:
- clk  input  1  system clock, rising edge.
- reset  input  1  asynchronous, active-high reset.
- rxEn  input  1  receiver enable; when low the receiver is held idle.
- rx  input  1  serial input; idles high.
- rxBusy  output  1  high while a frame is being received.
- rxDone  output  1  one-clk pulse when a byte has been received with a valid stop bit.
- rxErr  output  1  one-clk pulse when the stop bit is sampled low.
- out  output  8  last received byte; holds until the next good frame.
- txEn  input  1  transmitter enable.
- txStart  input  1  one-clk request to send `in`.
- in  input  8  byte to transmit; latched at accept.
- tx  output  1  serial output; idles high.
- txBusy  output  1  high from accept until the end of the stop bit.
- txDone  output  1  one-clk pulse at the end of the stop bit.

Behaviour:
- Reset (async) values:
  - rxBusy=0, rxDone=0, rxErr=0, out=0x00.
  - tx=1, txBusy=0, txDone=0.
  - All counters = 0.
- Baud ticks:
  - RX tick every RX_DIV = CLOCK_RATE/(BAUD_RATE*RX_OVERSAMPLE) clocks (integer floor; 78 at default).
  - TX tick every TX_DIV = CLOCK_RATE/BAUD_RATE clocks (1250 at default).
  - Each divider restarts from 0 whenever its state machine is in IDLE.
- rx is passed through a 2-flop synchronizer before use.
- RX FSM, states IDLE, START, DATA, STOP:
  - IDLE: when rxEn=1 and synced rx=0, go to START and clear the sample counter.
  - START: count 8 ticks (half a bit), then sample.
    - rx=1 means false start: return to IDLE with no error and no rxBusy glitch; rxBusy rises only on START confirmation.
    - rx=0: set rxBusy=1, go to DATA.
  - DATA: every 16 ticks sample rx and shift it in LSB-first (first data bit → out bit 0). After 8 bits go to STOP.
  - STOP: after 16 ticks sample rx.
    - rx=1: load `out`, pulse rxDone.
    - rx=0: pulse rxErr; `out` is unchanged.
    - In both cases clear rxBusy and return to IDLE immediately, at mid-stop-bit, so a start bit beginning 0.5 bit later is caught.
- rxEn driven low in any state aborts to IDLE: rxBusy=0, no pulse.
- Receiver must tolerate a transmitter clock about ±3% off nominal (the mid-bit sample margin).
- TX FSM, states IDLE, START, DATA, STOP:
  - IDLE: when txEn & txStart, latch `in`, set txBusy=1, tx=0 (start bit).
  - START: one bit time, then DATA.
  - DATA: 8 bits LSB-first, one bit per TX tick, then STOP.
  - STOP: tx=1 for one bit time, then pulse txDone, clear txBusy, return to IDLE.
  - txStart while txBusy is ignored.
  - txEn low aborts to IDLE with tx=1.
- Simultaneous RX and TX operation is independent.

Decomposition:
- Package uart_pkg:
  - FSM state enum: IDLE, START, DATA, STOP.
  - Divider width function (clog2).
- Sub-modules:
  - baud_tick_gen(DIV): counter with clear input, one-clk tick output; instantiated twice.
  - uart_rx and uart_tx: natural leaf modules; uart8 is a thin wrapper.

Test Plan:
- Reset then idle: rx=1 held for 2 ms → rxBusy=0, rxDone=0, rxErr=0, out=0x00, tx=1.
- Glitch rejection: rx low 16 µs, then high → no rxBusy, no rxDone, no rxErr; a valid frame starting 36 µs later is still received.
- Receive 0x56 with 107.5 µs bit periods (+3% slow) and a 71 µs stop bit → single rxDone pulse, out=0x56, rxErr=0; a start bit following the stop immediately is detected (rxBusy rises about 52 µs later).
- Framing error: send 0xA5 with the stop bit held low → rxErr pulse, no rxDone, out keeps its previous value.
- Transmit 0xA5 with txEn=1 and a txStart pulse → tx pattern 0,1,0,1,0,0,1,0,1,1 at 1250 clks per bit; txBusy high for 12500 clks, then a txDone pulse.
- rxEn=0 during a frame → rxBusy clears within 1 clk; a reset asserted mid-frame returns all outputs to their reset values asynchronously.
